// File: rtl/ext_mem_responder_if.sv
// CPU <-> external-memory responder bus.
// The master (CPU core) drives the request fields; the slave (responder)
// returns read data plus the ready/err/busy status.
interface ext_mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] external_memory;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (
      output req, we, addr, wdata,
      input  external_memory, ready, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output external_memory, ready, err, busy
   );
endinterface

// File: rtl/ext_mem_responder.sv
// External-memory responder: services CPU word reads/writes from an internal
// RAM after a programmable number of wait states. Bad addresses (misaligned,
// upper bits set, or beyond DEPTH) answer immediately with err and touch no RAM.
module ext_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   ext_mem_responder_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic                err_pend_q, err_pend_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         ext_q, ext_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;

   logic [31:0]         mem [DEPTH];

   // Decode of the request as presented on the bus this cycle.
   logic [ADDR_W-1:0]   req_idx;
   logic                req_err;

   // The access that is performed on the edge that enters RESP.
   logic                acc_go;
   logic                acc_we;
   logic                acc_err;
   logic [ADDR_W-1:0]   acc_idx;
   logic [31:0]         acc_wdata;
   logic                mem_wr;

   assign req_idx = bus.addr[ADDR_W+1:2];
   assign req_err = (bus.addr[1:0] != 2'b00)
                 || (bus.addr[31:ADDR_W+2] != '0)
                 || (32'(req_idx) >= 32'(DEPTH));

   // Next-state, latch and response computation for the request FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      err_pend_d = err_pend_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      ext_d      = ext_q;
      ready_d    = 1'b0;
      err_d      = 1'b0;
      acc_go     = 1'b0;
      acc_we     = we_q;
      acc_err    = err_pend_q;
      acc_idx    = idx_q;
      acc_wdata  = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               we_d       = bus.we;
               err_pend_d = req_err;
               idx_d      = req_idx;
               wdata_d    = bus.wdata;
               if (req_err || (WAIT_CYCLES == 0)) begin
                  // No wait states: the access uses the live bus values.
                  state_d   = S_RESP;
                  acc_go    = 1'b1;
                  acc_we    = bus.we;
                  acc_err   = req_err;
                  acc_idx   = req_idx;
                  acc_wdata = bus.wdata;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               acc_go  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (acc_go) begin
         ready_d = 1'b1;
         err_d   = acc_err;
         if (!acc_err && !acc_we) begin
            ext_d = mem[acc_idx];
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   // A reset asserted on the commit edge must not let a write slip through.
   assign mem_wr = acc_go && acc_we && !acc_err && !rst;

   // Control and output registers; all clear on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         err_pend_q <= 1'b0;
         ext_q      <= 32'd0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         err_pend_q <= err_pend_d;
         ext_q      <= ext_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   // Latched request payload; only consumed after being written in IDLE.
   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   // Word RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign bus.external_memory = ext_q;
   assign bus.ready           = ready_q;
   assign bus.err             = err_q;
   assign bus.busy            = busy_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: directed scenarios plus randomized traffic,
// checked against a transaction-level model (word array + last-read register).
module tb_ext_mem_responder;

   localparam int ADDR_W      = 8;
   localparam int DEPTH       = 256;
   localparam int WAIT_CYCLES = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ext_mem_responder_if bus ();

   ext_mem_responder #(
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_ext;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || ((a / 4) >= DEPTH);
   endfunction

   // One request with idle bus before and after; checks latency, err,
   // returned data, busy while responding and the one-cycle ready width.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
      int n;
      bit bad;
      int lat;
      bad = addr_bad(a);
      lat = bad ? 0 : WAIT_CYCLES;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      n = 0;
      while (bus.ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bad) begin
         if (w) ref_mem[a / 4] = d;
         else   ref_ext = ref_mem[a / 4];
      end
      check({tag, ".lat"}, n, lat);
      check({tag, ".err"}, {31'd0, bus.err}, {31'd0, bad});
      check({tag, ".data"}, bus.external_memory, ref_ext);
      check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check({tag, ".rdy_w"}, {31'd0, bus.ready}, 32'd0);
   endtask

   initial begin
      int pulses;
      int idles;
      int t;
      int first_t;
      int last_t;
      logic [31:0] a;
      int kind;

      rst       = 1'b1;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 32'd0;
      bus.wdata = 32'd0;
      ref_ext   = 32'd0;

      // Reset
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst.data",  bus.external_memory, 32'd0);
      check("rst.ready", {31'd0, bus.ready}, 32'd0);
      check("rst.err",   {31'd0, bus.err},   32'd0);
      check("rst.busy",  {31'd0, bus.busy},  32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle.busy", {31'd0, bus.busy}, 32'd0);
      end

      // Preload every word (word 0 gets zero)
      for (int i = 0; i < DEPTH; i++) begin
         txn(1'b1, 32'(i * 4), (i == 0) ? 32'd0 : $urandom, "pre");
      end

      // Write then read 0x10
      txn(1'b1, 32'h10, 32'hDEADBEEF, "wr10");
      txn(1'b0, 32'h10, 32'h0, "rd10");
      check("rd10.val", bus.external_memory, 32'hDEADBEEF);

      // Misaligned read
      txn(1'b0, 32'h13, 32'h0, "misal");
      check("misal.keep", bus.external_memory, 32'hDEADBEEF);

      // Out-of-range write then read of word 0
      txn(1'b1, 32'h400, 32'h12345678, "oor");
      txn(1'b0, 32'h0, 32'h0, "rd0");
      check("rd0.val", bus.external_memory, 32'd0);

      // Request pulsed during WAIT is ignored
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      bus.we    = 1'b1;
      bus.addr  = 32'h20;
      bus.wdata = 32'h55555555;
      @(negedge clk);
      bus.req = 1'b0;
      ref_ext = ref_mem[4];
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.ready === 1'b1) pulses++;
         @(negedge clk);
      end
      check("ign.pulses", pulses, 1);
      check("ign.data", bus.external_memory, ref_ext);

      // req held high: three back-to-back reads
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 32'h10;
      pulses = 0;
      idles = 0;
      first_t = 0;
      last_t = 0;
      for (t = 0; t < 60; t++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            pulses++;
            if (pulses == 1) first_t = t;
            last_t = t;
            if (pulses == 3) break;
         end else if (bus.busy === 1'b0 && pulses > 0) begin
            idles++;
         end
      end
      bus.req = 1'b0;
      ref_ext = ref_mem[4];
      check("held.pulses", pulses, 3);
      check("held.idles", idles, 2);
      check("held.gap", last_t - first_t, 2 * (WAIT_CYCLES + 2));
      check("held.data", bus.external_memory, ref_ext);
      t = 0;
      while (bus.busy !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("held.drain", {31'd0, bus.busy}, 32'd0);

      // Reset during WAIT aborts the write
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'h20;
      bus.wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      rst = 1'b1;
      #1;
      ref_ext = 32'd0;
      check("abort.data",  bus.external_memory, 32'd0);
      check("abort.ready", {31'd0, bus.ready}, 32'd0);
      check("abort.err",   {31'd0, bus.err},   32'd0);
      check("abort.busy",  {31'd0, bus.busy},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) pulses++;
      end
      check("abort.pulses", pulses, 0);
      txn(1'b0, 32'h20, 32'h0, "abort.rd");
      check("abort.old", {31'd0, bus.external_memory == 32'hCAFEF00D}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 9);
         if (kind < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (kind == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else                a = $urandom;
         txn(1'($urandom_range(0, 1)), a, $urandom, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
Responder end of the CPU external-memory interface. The CPU core initiates word read/write requests; this block services them from an internal word RAM and drives the 32-bit external_memory data word back to the core. A programmable wait-state counter models slow memory, and ready/err report completion.

Parameters:
ADDR_W, 8, word-index width; RAM holds DEPTH words indexed by addr[ADDR_W+1:2].
DEPTH, 256, number of 32-bit words; must be <= 2**ADDR_W.
WAIT_CYCLES, 2, wait states inserted before the response (0..15).

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-high reset
req  in  1  request strobe, sampled only in IDLE
we  in  1  1 = write, 0 = read; latched with req
addr  in  32  byte address; latched with req
wdata  in  32  write data; latched with req
external_memory  out  32  read data returned to the CPU (registered)
ready  out  1  one-cycle completion pulse
err  out  1  error flag, valid while ready = 1
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst = 1): state goes to IDLE; external_memory = 0, ready = 0, err = 0, busy = 0, wait counter = 0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE: req = 1 at edge k latches we, addr and wdata.
  - Error check: err_pend = (addr[1:0] != 0) or (addr[31:ADDR_W+2] != 0) or (index >= DEPTH).
  - If err_pend = 1 or WAIT_CYCLES = 0, go to RESP. Otherwise go to WAIT with counter = WAIT_CYCLES-1.
- WAIT: counter decrements on each edge. At the edge where counter = 0, go to RESP.
- Entering RESP (same edge): perform the access.
  - Read, no error: external_memory <= mem[index].
  - Write, no error: mem[index] <= wdata; external_memory unchanged.
  - Error: no RAM access; external_memory unchanged.
- RESP: ready = 1 and err = err_pend for exactly one cycle. Next edge returns to IDLE unconditionally.
- Latency: with req sampled at edge k, ready is high from edge k+WAIT_CYCLES to edge k+WAIT_CYCLES+1. Error responses always use WAIT_CYCLES = 0 timing.
- external_memory holds the last successful read value until the next successful read.
- req is ignored in WAIT and RESP; no queuing.
- req held high continuously issues back-to-back transactions, with one IDLE cycle between ready pulses.
- Reset mid-WAIT aborts the transaction: the pending write is not committed and ready does not pulse.
- Reset during RESP: the access has already been performed; outputs clear immediately.
- ready and err are registered, never combinational from req.

Test Plan:
- Reset check: rst = 1 at time 0, hold 1 cycle, release -> external_memory = 0, ready = 0, err = 0, busy = 0; busy stays low with req = 0.
- WAIT_CYCLES = 2: write 32'hDEADBEEF to addr 0x10, then read 0x10 -> each ready pulse is 1 cycle wide, 2 edges after the sampling edge; err = 0; read returns external_memory = 32'hDEADBEEF.
- Misaligned read of addr 0x13 -> ready = 1 and err = 1 one cycle after sampling, no wait states; external_memory keeps 32'hDEADBEEF.
- Out-of-range write of 32'h12345678 to addr 0x400 -> err = 1; a subsequent read of 0x000 returns the prior value (0 after preload) with err = 0.
- req pulsed during WAIT of a read to 0x10 -> ignored; exactly one ready pulse. req held high for 3 transactions -> 3 ready pulses, each separated by one IDLE cycle.
- Write 32'hCAFEF00D to 0x20, assert rst during WAIT -> outputs clear immediately, no ready pulse; after release, read 0x20 returns its previous value, not 32'hCAFEF00D.
